// File: rtl/period_meter.sv
// period_meter: measures, in clk cycles, the period and high time of an asynchronous
// periodic input between consecutive synchronized rising edges.
module period_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             timeout,
  output logic             locked
);
  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;
  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_d_q;
  logic [CNT_W-1:0]       cnt_q, hcnt_q, period_q, high_q;
  logic                   valid_q, timeout_q, locked_q;
  logic                   sig_s, rise;
  assign sig_s     = sync_q[SYNC_STAGES-1];
  assign rise      = sig_s & ~sig_d_q;
  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;
  assign locked    = locked_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      sig_d_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_in};
      sig_d_q <= sig_s;
    end
  end
  // A rise always wins over saturation; saturation falls back to ARM without a result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!en) begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        hcnt_q   <= '0;
        locked_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: state_q <= ARM;
          ARM: if (rise) begin
            state_q <= MEASURE;
            cnt_q   <= CNT_W'(1);
            hcnt_q  <= CNT_W'(1);
          end
          MEASURE: if (rise) begin
            period_q  <= cnt_q;
            high_q    <= hcnt_q;
            valid_q   <= 1'b1;
            locked_q  <= 1'b1;
            timeout_q <= 1'b0;
            cnt_q     <= CNT_W'(1);
            hcnt_q    <= CNT_W'(1);
          end else if (&cnt_q) begin
            timeout_q <= 1'b1;
            locked_q  <= 1'b0;
            state_q   <= ARM;
          end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
            hcnt_q <= hcnt_q + CNT_W'(sig_s);
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed stimulus with a result scoreboard for period_meter (CNT_W=4).
module tb_period_meter;
  localparam int W = 4;
  logic clk = 0, rst = 1, en = 0, sig_in = 0;
  logic [W-1:0] period, high_time;
  logic valid, timeout, locked;
  int checks = 0, errors = 0, stepn = 0, last_v = -1, exp_gap = 0;
  int prev_p = 0, prev_h = 0;
  logic have_prev = 0, pv = 0;
  logic [2*W-1:0] q[$];

  period_meter #(.CNT_W(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .period(period), .high_time(high_time),
    .valid(valid), .timeout(timeout), .locked(locked)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic v);
    logic [2*W-1:0] e;
    sig_in = v;
    @(posedge clk);
    #1;
    stepn++;
    if (valid) begin
      chk("unexpected_valid", 32'(q.size() == 0), 0);
      chk("valid_twice", 32'(pv), 0);
      if (exp_gap != 0 && last_v >= 0) chk("valid_gap", 32'(stepn - last_v), 32'(exp_gap));
      last_v = stepn;
      chk("valid_timeout", 32'(timeout), 0);
      chk("valid_locked", 32'(locked), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("period", 32'(period), 32'(e[2*W-1:W]));
        chk("high_time", 32'(high_time), 32'(e[W-1:0]));
      end
    end
    pv = valid;
  endtask

  // The period started by this rise is reported at the next rise, if the meter is armed.
  task automatic wave(input int p, input int h);
    if (have_prev) q.push_back({W'(prev_p), W'(prev_h)});
    prev_p = p;
    prev_h = h;
    have_prev = en;
    for (int i = 0; i < p; i++) step(i < h);
  endtask

  task automatic tail();
    wave(8, 1);
    en = 0;
    have_prev = 0;
    repeat (3) step(0);
    chk("tail_queue_empty", 32'(q.size()), 0);
    chk("tail_locked", 32'(locked), 0);
  endtask

  initial begin
    #1 rst = 0;
    #1;
    chk("rst_period", 32'(period), 0);
    chk("rst_high_time", 32'(high_time), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_locked", 32'(locked), 0);
    #10 rst = 1;
    repeat (3) wave(4, 2);
    repeat (5) step(0);
    chk("en_low_locked", 32'(locked), 0);
    chk("en_low_queue", 32'(q.size()), 0);
    en = 1;
    repeat (4) step(0);
    exp_gap = 4; last_v = -1;
    repeat (6) wave(4, 2);
    chk("basic_locked", 32'(locked), 1);
    exp_gap = 5; last_v = -1;
    repeat (4) wave(5, 1);
    exp_gap = 0;
    wave(6, 1);
    repeat (3) wave(7, 4);
    if (have_prev) q.push_back({W'(prev_p), W'(prev_h)});
    have_prev = 0;
    for (int j = 0; j < 22; j++) begin
      step(j < 4);
      if (j == 16) begin
        chk("pre_timeout", 32'(timeout), 0);
        chk("pre_timeout_locked", 32'(locked), 1);
      end
      if (j == 17) begin
        chk("timeout_set", 32'(timeout), 1);
        chk("timeout_locked", 32'(locked), 0);
        chk("timeout_period_hold", 32'(period), 7);
        chk("timeout_high_hold", 32'(high_time), 4);
      end
    end
    chk("timeout_sticky", 32'(timeout), 1);
    wave(4, 2);
    chk("timeout_until_valid", 32'(timeout), 1);
    wave(4, 2);
    wave(4, 2);
    chk("timeout_cleared", 32'(timeout), 0);
    tail();
    chk("idle_period_hold", 32'(period), 4);
    chk("idle_high_hold", 32'(high_time), 2);
    en = 1;
    repeat (3) step(0);
    repeat (3) wave(5, 2);
    if (have_prev) q.push_back({W'(prev_p), W'(prev_h)});
    have_prev = 0;
    step(1); step(1); step(0);
    #3 rst = 0;
    #1;
    chk("arst_period", 32'(period), 0);
    chk("arst_high_time", 32'(high_time), 0);
    chk("arst_valid", 32'(valid), 0);
    chk("arst_timeout", 32'(timeout), 0);
    chk("arst_locked", 32'(locked), 0);
    q.delete();
    sig_in = 0;
    #2 rst = 1;
    repeat (3) step(0);
    wave(5, 2);
    chk("arst_first_edge_locked", 32'(locked), 0);
    repeat (2) wave(5, 2);
    tail();
    en = 1;
    repeat (3) step(0);
    exp_gap = 2; last_v = -1;
    repeat (6) wave(2, 1);
    tail();
    exp_gap = 0;
    chk("min_period_hold", 32'(period), 2);
    chk("min_high_hold", 32'(high_time), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
